// File: rtl/ballot_pkg.sv
// ---------------------------------------------------------------------------
// ballot_pkg
// Shared definitions for the ballot entry front-end: candidate count, FSM
// state encoding and selection-vector helpers.
// ---------------------------------------------------------------------------
package ballot_pkg;

  localparam int NUM_CAND = 4;

  localparam logic [NUM_CAND-1:0] CAND_ZERO = {NUM_CAND{1'b0}};
  localparam logic [NUM_CAND-1:0] CAND_ONE  = {{(NUM_CAND-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAST    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // True when at least two bits are set (clearing the lowest set bit leaves a remainder).
  function automatic logic is_multi(input logic [NUM_CAND-1:0] v);
    return ((v & (v - CAND_ONE)) != CAND_ZERO);
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return ((v != CAND_ZERO) && !is_multi(v));
  endfunction

endpackage

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
// Two-flop synchronizer followed by a debouncer for one asynchronous button.
// Ports:
//   i_clk   - block clock
//   i_rst   - synchronous active-high reset
//   i_raw   - asynchronous raw button level
//   o_level - debounced level (registered)
//   o_rise  - one-cycle pulse in the cycle o_level goes 0 -> 1 (registered)
// ---------------------------------------------------------------------------
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after a full run of agreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        // Any sample matching the current level restarts the run.
        r_cnt  <= CNT_ZERO;
        r_rise <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= CNT_ZERO;
        r_level <= r_sync;
        r_rise  <= r_sync;
      end else begin
        r_cnt  <= r_cnt + CNT_ONE;
        r_rise <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/ballot_entry.sv
// ---------------------------------------------------------------------------
// ballot_entry
// Front-end for the voting tally: conditions candidate/cast buttons, enforces
// a single one-hot selection, and hands each ballot downstream exactly once
// over valid/ready, followed by a lockout against double votes.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   btn_raw[3:0] - async candidate buttons (active-high)
//   cast_raw     - async cast button (active-high)
//   enable       - voting mode active
//   vote_onehot  - ballot, meaningful while vote_valid
//   vote_valid   - ballot offered; held until vote_ready
//   vote_ready   - downstream accepts
//   selected     - armed selection (LEDs)
//   busy         - in CAST or LOCKOUT
//   err_multi    - one-cycle pulse on a multi-button selection
//   ballots[7:0] - accepted ballot count, saturating at 255
// All outputs are registered.
// ---------------------------------------------------------------------------
module ballot_entry
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CAND-1:0] btn_raw,
  input  logic                cast_raw,
  input  logic                enable,
  output logic [NUM_CAND-1:0] vote_onehot,
  output logic                vote_valid,
  input  logic                vote_ready,
  output logic [NUM_CAND-1:0] selected,
  output logic                busy,
  output logic                err_multi,
  output logic [7:0]          ballots
);

  localparam int            LW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  // Loading N-1 and exiting on the zero cycle gives exactly N cycles in LOCKOUT.
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  logic [NUM_CAND-1:0] w_cand_level;
  logic [NUM_CAND-1:0] w_cand_rise;
  logic                w_cast_level;
  logic                w_cast_rise;
  logic                w_cand_press;

  state_e              r_state;
  logic [NUM_CAND-1:0] r_selected;
  logic [NUM_CAND-1:0] r_vote_onehot;
  logic                r_vote_valid;
  logic                r_busy;
  logic                r_err_multi;
  logic [7:0]          r_ballots;
  logic [LW-1:0]       r_lock_cnt;

  state_e              w_state_nxt;
  logic [NUM_CAND-1:0] w_selected_nxt;
  logic [NUM_CAND-1:0] w_onehot_nxt;
  logic                w_valid_nxt;
  logic                w_err_nxt;
  logic [7:0]          w_ballots_nxt;
  logic [LW-1:0]       w_lock_nxt;
  logic                w_busy_nxt;

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_raw   (btn_raw[gi]),
      .o_level (w_cand_level[gi]),
      .o_rise  (w_cand_rise[gi])
    );
  end

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cast (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_raw   (cast_raw),
    .o_level (w_cast_level),
    .o_rise  (w_cast_rise)
  );

  assign w_cand_press = |w_cand_rise;

  // Next-state logic for the FSM and every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_selected_nxt = r_selected;
    w_onehot_nxt   = r_vote_onehot;
    w_valid_nxt    = r_vote_valid;
    w_err_nxt      = 1'b0;
    w_ballots_nxt  = r_ballots;
    w_lock_nxt     = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_cand_press && enable) begin
          if (is_onehot(w_cand_level)) begin
            w_selected_nxt = w_cand_level;
            w_state_nxt    = ST_ARMED;
          end else begin
            w_err_nxt = is_multi(w_cand_level);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          w_selected_nxt = CAND_ZERO;
          w_state_nxt    = ST_IDLE;
        end else if (w_cast_rise) begin
          // Cast wins over a same-cycle candidate press: ballot uses the old selection.
          w_onehot_nxt = r_selected;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = ST_CAST;
        end else if (w_cand_press) begin
          if (is_onehot(w_cand_level)) begin
            w_selected_nxt = w_cand_level;
          end else begin
            w_err_nxt = is_multi(w_cand_level);
          end
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_CAST: begin
        // Offered ballot is held regardless of enable until the handshake completes.
        if (r_vote_valid && vote_ready) begin
          w_ballots_nxt  = (r_ballots == 8'hFF) ? 8'hFF : (r_ballots + 8'd1);
          w_selected_nxt = CAND_ZERO;
          w_onehot_nxt   = CAND_ZERO;
          w_valid_nxt    = 1'b0;
          w_lock_nxt     = LOCK_LOAD;
          w_state_nxt    = ST_LOCKOUT;
        end else begin
          w_state_nxt = ST_CAST;
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_cnt != LOCK_ZERO) begin
          w_lock_nxt = r_lock_cnt - LOCK_ONE;
        end else if ((w_cand_level == CAND_ZERO) && !w_cast_level) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_selected_nxt = CAND_ZERO;
        w_onehot_nxt   = CAND_ZERO;
        w_valid_nxt    = 1'b0;
        w_lock_nxt     = LOCK_ZERO;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_CAST) || (w_state_nxt == ST_LOCKOUT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_selected    <= CAND_ZERO;
      r_vote_onehot <= CAND_ZERO;
      r_vote_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_err_multi   <= 1'b0;
      r_ballots     <= 8'd0;
      r_lock_cnt    <= LOCK_ZERO;
    end else begin
      r_state       <= w_state_nxt;
      r_selected    <= w_selected_nxt;
      r_vote_onehot <= w_onehot_nxt;
      r_vote_valid  <= w_valid_nxt;
      r_busy        <= w_busy_nxt;
      r_err_multi   <= w_err_nxt;
      r_ballots     <= w_ballots_nxt;
      r_lock_cnt    <= w_lock_nxt;
    end
  end

  assign vote_onehot = r_vote_onehot;
  assign vote_valid  = r_vote_valid;
  assign selected    = r_selected;
  assign busy        = r_busy;
  assign err_multi   = r_err_multi;
  assign ballots     = r_ballots;

endmodule

// File: tb/tb_ballot_entry.sv
// ---------------------------------------------------------------------------
// tb_ballot_entry
// Scoreboarded bench for ballot_entry (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8).
// Stimulus pushes each expected ballot into a queue; a monitor pops and
// compares on every completed handshake. Directed checks cover reset values,
// debounce, multi-press, backpressure, lockout, saturation and reset mid-CAST.
// ---------------------------------------------------------------------------
module tb_ballot_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       cast_raw;
  logic       enable;
  logic [3:0] vote_onehot;
  logic       vote_valid;
  logic       vote_ready;
  logic [3:0] selected;
  logic       busy;
  logic       err_multi;
  logic [7:0] ballots;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_cycles = 0;
  int n_err_pulses = 0;
  int n_accepts = 0;
  int n_busy_cycles = 0;
  logic [3:0] exp_q[$];

  ballot_entry #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .cast_raw    (cast_raw),
    .enable      (enable),
    .vote_onehot (vote_onehot),
    .vote_valid  (vote_valid),
    .vote_ready  (vote_ready),
    .selected    (selected),
    .busy        (busy),
    .err_multi   (err_multi),
    .ballots     (ballots)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < 200) begin
      tick(1);
      k++;
    end
    check(name, busy, lvl);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (vote_valid !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    check(name, vote_valid, 1'b1);
  endtask

  task automatic do_ballot(input logic [3:0] oh);
    btn_raw = oh;
    tick(8);
    btn_raw = 4'b0000;
    tick(8);
    exp_q.push_back(oh);
    cast_raw = 1'b1;
    tick(8);
    cast_raw = 1'b0;
    wait_busy(1'b0, "ballot_idle");
  endtask

  // Monitor: counts output events and scores every completed handshake.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (vote_valid === 1'b1) n_valid_cycles++;
      if (err_multi === 1'b1) n_err_pulses++;
      if (busy === 1'b1) n_busy_cycles++;
      if (vote_valid === 1'b1 && vote_ready === 1'b1) begin
        n_accepts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ballot: got %0h expected none", vote_onehot);
        end else begin
          e = exp_q.pop_front();
          check("ballot_onehot", vote_onehot, e);
        end
      end
    end
  end

  initial begin
    int v0, e0, a0, b0;
    rst = 1'b1; btn_raw = 4'b0000; cast_raw = 1'b0; enable = 1'b0; vote_ready = 1'b0;
    tick(3);
    check("rst_onehot", vote_onehot, 4'b0000);
    check("rst_valid", vote_valid, 1'b0);
    check("rst_selected", selected, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_multi, 1'b0);
    check("rst_ballots", ballots, 8'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick(2);

    // Bounce: 2-cycle toggles never satisfy the 4-sample run.
    e0 = n_err_pulses;
    for (int i = 0; i < 20; i++) begin
      btn_raw[1] = ((i % 4) < 2);
      tick(1);
    end
    check("bounce_no_select", selected, 4'b0000);
    btn_raw = 4'b0010;
    tick(6);
    check("bounce_not_yet", selected, 4'b0000);
    tick(1);
    check("bounce_selected", selected, 4'b0010);
    check("bounce_no_err", n_err_pulses - e0, 0);
    btn_raw = 4'b0000;
    tick(8);

    // Single vote: new press replaces the armed selection, then cast.
    btn_raw = 4'b0100;
    tick(8);
    btn_raw = 4'b0000;
    tick(8);
    check("single_armed", selected, 4'b0100);
    vote_ready = 1'b1;
    v0 = n_valid_cycles;
    b0 = n_busy_cycles;
    exp_q.push_back(4'b0100);
    cast_raw = 1'b1;
    tick(8);
    cast_raw = 1'b0;
    wait_busy(1'b0, "single_idle");
    check("single_valid_cycles", n_valid_cycles - v0, 1);
    check("single_ballots", ballots, 8'd1);
    check("single_selected_clr", selected, 4'b0000);
    n_checks++;
    if (n_busy_cycles - b0 < 9) begin
      n_errors++;
      $display("FAIL single_busy_len: got %0d cycles expected at least 9", n_busy_cycles - b0);
    end

    // Multi-press: error pulse once, no selection, cast does nothing.
    e0 = n_err_pulses;
    v0 = n_valid_cycles;
    btn_raw = 4'b0011;
    tick(10);
    check("multi_err_once", n_err_pulses - e0, 1);
    check("multi_selected", selected, 4'b0000);
    btn_raw = 4'b0000;
    tick(8);
    cast_raw = 1'b1;
    tick(8);
    cast_raw = 1'b0;
    tick(10);
    check("multi_no_valid", n_valid_cycles - v0, 0);
    check("multi_not_busy", busy, 1'b0);

    // Backpressure: ballot stays put while enable and buttons wiggle.
    vote_ready = 1'b0;
    btn_raw = 4'b1000;
    tick(8);
    btn_raw = 4'b0000;
    tick(8);
    exp_q.push_back(4'b1000);
    cast_raw = 1'b1;
    wait_valid("bp_valid_rise");
    a0 = n_accepts;
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      btn_raw = 4'(i);
      cast_raw = i[1];
      tick(1);
      check("bp_valid_hold", vote_valid, 1'b1);
      check("bp_onehot_hold", vote_onehot, 4'b1000);
    end
    btn_raw = 4'b0000;
    cast_raw = 1'b0;
    enable = 1'b1;
    vote_ready = 1'b1;
    tick(1);
    check("bp_valid_drop", vote_valid, 1'b0);
    wait_busy(1'b0, "bp_idle");
    check("bp_accept_once", n_accepts - a0, 1);
    check("bp_ballots", ballots, 8'd2);

    // Lockout hold: held candidate keeps LOCKOUT alive, repeat cast ignored.
    a0 = n_accepts;
    btn_raw = 4'b0001;
    tick(8);
    exp_q.push_back(4'b0001);
    cast_raw = 1'b1;
    tick(8);
    cast_raw = 1'b0;
    tick(30);
    check("lock_held_busy", busy, 1'b1);
    cast_raw = 1'b1;
    tick(8);
    cast_raw = 1'b0;
    tick(8);
    check("lock_still_busy", busy, 1'b1);
    check("lock_one_ballot", n_accepts - a0, 1);
    btn_raw = 4'b0000;
    wait_busy(1'b0, "lock_release_idle");
    check("lock_ballots", ballots, 8'd3);

    // Saturation: 254 more ballots bring the total to 257.
    for (int i = 0; i < 254; i++) begin
      do_ballot(4'b0001 << (i % 4));
      if (i == 251) check("sat_reach_255", ballots, 8'd255);
    end
    check("sat_hold_255", ballots, 8'd255);
    check("sat_delivered", n_accepts, 257);

    // Reset during CAST: the offered ballot is dropped.
    vote_ready = 1'b0;
    btn_raw = 4'b0010;
    tick(8);
    btn_raw = 4'b0000;
    tick(8);
    cast_raw = 1'b1;
    wait_valid("rst_cast_valid");
    rst = 1'b1;
    tick(1);
    check("rst_mid_valid", vote_valid, 1'b0);
    check("rst_mid_onehot", vote_onehot, 4'b0000);
    check("rst_mid_selected", selected, 4'b0000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_err", err_multi, 1'b0);
    check("rst_mid_ballots", ballots, 8'd0);
    cast_raw = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ballot_entry.md
# ballot_entry

Upstream front-end for the voting tally stage. Conditions the raw candidate buttons and cast button, enforces a single one-hot selection per ballot, and delivers each ballot exactly once over a valid/ready handshake. A post-cast lockout prevents double votes. Its outputs replace direct button wiring into the tally counters.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronized samples required before an input change is accepted (≥2).
- `LOCKOUT_CYCLES`, default 64: minimum cycles spent in LOCKOUT after a ballot is accepted (≥1).

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in 4: asynchronous candidate buttons, bit i = candidate i, active-high.
- `cast_raw` in 1: asynchronous cast/confirm button, active-high.
- `enable` in 1: voting mode active; downstream drives it high only in voting mode.
- `vote_onehot` out 4: ballot one-hot; meaningful only while `vote_valid` = 1.
- `vote_valid` out 1: ballot offered downstream.
- `vote_ready` in 1: downstream accepts the ballot.
- `selected` out 4: currently armed selection, for LEDs.
- `busy` out 1: high in CAST or LOCKOUT.
- `err_multi` out 1: one-cycle pulse on an invalid multi-button selection.
- `ballots` out 8: count of accepted ballots; saturates at 255.

## Operation
- Every raw input passes through a 2-flop synchronizer, then a debouncer. The debounced output changes only after `DEBOUNCE_CYCLES` consecutive samples equal the new value. Any mismatch restarts the count.
- Press events are the rising edges of the debounced signals.
- FSM states: IDLE, ARMED, CAST, LOCKOUT.
- IDLE:
  - On any candidate press event with `enable` = 1, sample the debounced candidate vector.
  - Exactly one bit set: latch it into `selected` and go to ARMED.
  - Zero or more than one bit set: pulse `err_multi` (more than one only) and stay in IDLE.
  - Cast press events are ignored.
- ARMED:
  - A new candidate press with exactly one debounced bit set replaces `selected`.
  - A press with more than one bit set pulses `err_multi` and keeps the old selection.
  - Cast press goes to CAST. If a candidate press and a cast press occur in the same cycle, the cast wins and uses the previously latched selection.
  - `enable` = 0 returns to IDLE and clears `selected`.
- CAST:
  - `vote_valid` = 1 and `vote_onehot` = `selected`; both are held stable until `vote_ready` = 1.
  - The handshake completes when `vote_valid` and `vote_ready` are both 1 on a rising edge.
  - On completion: increment `ballots` (saturating), clear `selected`, load the lockout counter, go to LOCKOUT.
  - `enable` dropping does not abort CAST; an offered ballot is never withdrawn.
- LOCKOUT:
  - Ignore all press events.
  - Exit to IDLE only when the counter has expired and all debounced inputs (4 candidates + cast) are 0.
- `busy` = (state == CAST) or (state == LOCKOUT).

## Timing
- Reset values: state IDLE; `vote_onehot`, `selected`, `ballots` = 0; `vote_valid`, `busy`, `err_multi` = 0. Synchronizers, debouncers and lockout counter are all cleared.
- Reset asserted mid-CAST drops `vote_valid` on the next cycle; the ballot is lost by design.
- Raw input to press event: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- Press event to state change: 1 cycle (registered FSM).
- Cast press event to `vote_valid` high: 1 cycle.
- `vote_ready` may be held high permanently. The minimum CAST dwell is then 1 cycle.
- LOCKOUT lasts at least `LOCKOUT_CYCLES` cycles, counted from the cycle after acceptance.
- `ballots` at 255 stays at 255; further ballots are still delivered.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `ballot_pkg`:
  - state enum (IDLE/ARMED/CAST/LOCKOUT);
  - `NUM_CAND` = 4;
  - function `is_onehot(logic [3:0])`.
- Sub-module `input_debounce` (parameter `DEBOUNCE_CYCLES`): 2-flop synchronizer, debounce counter, registered level output plus a rise pulse. Instantiated 5 times.
- Top level contains the FSM, selection register, lockout counter and ballot counter.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES` = 4 and `LOCKOUT_CYCLES` = 8.
- **Single vote:** press `btn_raw` = 4'b0100, release, pulse cast, `vote_ready` = 1 → one cycle of `vote_valid` with `vote_onehot` = 4'b0100; `ballots` = 1; `busy` high ≥ 8 cycles.
- **Bounce:** toggle `btn_raw[1]` every 2 cycles for 20 cycles, then hold → exactly one press event, `selected` = 4'b0010 only after 4 stable cycles.
- **Multi-press:** hold `btn_raw` = 4'b0011 → `err_multi` pulses once, `selected` stays 0; casting afterwards produces no `vote_valid`.
- **Backpressure:** armed with 4'b1000, cast with `vote_ready` = 0 for 10 cycles, toggle `enable` and buttons meanwhile → `vote_valid` and `vote_onehot` = 4'b1000 stay stable; accepted when `vote_ready` rises; `ballots` increments once.
- **Lockout hold:** keep `btn_raw[0]` held after acceptance → remain in LOCKOUT past 8 cycles until release; no second ballot.
- **Saturation and reset:** deliver 257 ballots → `ballots` = 255. Assert `rst` during CAST → `vote_valid` = 0 next cycle and all outputs return to reset values.
